// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: round-robin IF/DBG arbiter that reads four consecutive
// bytes from a byte-wide instruction memory and returns a big-endian word.
module imem_fetch_arbiter #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_inst,
  input  logic              dbg_req,
  input  logic [31:0]       dbg_addr,
  output logic              dbg_ack,
  output logic [31:0]       dbg_data,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_byte,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Owner / last_grant encoding: 1 = DBG, 0 = IF.
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [31:0]       word_q, word_d;

  logic              if_ack_d, dbg_ack_d, mem_rd_d, busy_d;
  logic [31:0]       if_inst_d, dbg_data_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              grant_dbg;
  logic [31:0]       word_full;

  // Address bits above the memory width are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr[31:ADDR_W], dbg_addr[31:ADDR_W]};

  // DBG wins if it is the only requester, or on contention when IF went last.
  assign grant_dbg = dbg_req & (~if_req | (last_grant_q == OWN_IF));

  // Final word including the byte captured in the cnt=3 cycle.
  assign word_full = {word_q[31:8], mem_byte};

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      base_q       <= '0;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_DBG;
      word_q       <= 32'd0;
      if_ack       <= 1'b0;
      dbg_ack      <= 1'b0;
      if_inst      <= 32'd0;
      dbg_data     <= 32'd0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      word_q       <= word_d;
      if_ack       <= if_ack_d;
      dbg_ack      <= dbg_ack_d;
      if_inst      <= if_inst_d;
      dbg_data     <= dbg_data_d;
      mem_rd       <= mem_rd_d;
      mem_addr     <= mem_addr_d;
      busy         <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    word_d       = word_q;
    if_ack_d     = 1'b0;
    dbg_ack_d    = 1'b0;
    if_inst_d    = if_inst;
    dbg_data_d   = dbg_data;
    mem_addr_d   = mem_addr;

    case (state_q)
      ST_IDLE: begin
        if (if_req || dbg_req) begin
          state_d      = ST_RD;
          cnt_d        = 2'd0;
          owner_d      = grant_dbg;
          last_grant_d = grant_dbg;
          base_d       = grant_dbg ? dbg_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
          mem_addr_d   = base_d;
        end
      end
      ST_RD: begin
        case (cnt_q)
          2'd0:    word_d[31:24] = mem_byte;
          2'd1:    word_d[23:16] = mem_byte;
          2'd2:    word_d[15:8]  = mem_byte;
          default: word_d[7:0]   = mem_byte;
        endcase
        if (cnt_q == 2'd3) begin
          state_d = ST_ACK;
          if (owner_q == OWN_DBG) begin
            dbg_ack_d  = 1'b1;
            dbg_data_d = word_full;
          end else begin
            if_ack_d  = 1'b1;
            if_inst_d = word_full;
          end
        end else begin
          cnt_d      = cnt_q + 2'd1;
          mem_addr_d = base_q + ADDR_W'(cnt_d);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    mem_rd_d = (state_d == ST_RD);
    busy_d   = (state_d != ST_IDLE);
  end

endmodule
